// File: rtl/highpass_fir.sv
// highpass_fir: streaming TAP_CNT-tap FIR filter on IEEE-754 binary32 samples.
// Products and the fixed-order accumulation are combinational; one registered result per accepted sample.
module highpass_fir #(
  parameter int TAP_CNT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] data_in,
  output logic        valid_out,
  output logic [31:0] data_out
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef logic [0:TAP_CNT-1][31:0] coeff_vec_t;
  typedef logic [0:TAP_CNT-2][31:0] hist_vec_t;

  localparam logic [0:15][31:0] HALF_31 = {
    32'hA1381601, 32'hBA9DBDB2, 32'hBB36C8A9, 32'hBB8AC191,
    32'hBB816A82, 32'h22325551, 32'h3C07824B, 32'h3C987E0D,
    32'h3CD058CF, 32'hBCAE415B ^ 32'h8000_0000, 32'hA2DD7A7A, 32'hBD226DB2,
    32'hBDBC821D, 32'hBE14D580, 32'hBE3DA98F, 32'h3F4CCCCD
  };

  // The 31-tap design is symmetric, so only the first half (including the centre) is listed.
  function automatic coeff_vec_t default_coeffs();
    coeff_vec_t c;
    c = '0;
    if (TAP_CNT == 31) begin
      for (int i = 0; i < 16; i++) begin
        c[i]             = HALF_31[i];
        c[TAP_CNT-1-i]   = HALF_31[i];
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] ftz(input logic [31:0] v);
    return (v[30:23] == 8'h00) ? {v[31], 31'h0} : v;
  endfunction

  // Round-to-nearest-even on a 24-bit significand, then saturate to Inf or flush to signed zero.
  function automatic logic [31:0] pack_round(input logic sign, input int exp_in,
                                             input logic [23:0] sig_in, input logic guard,
                                             input logic sticky);
    logic [24:0] sig_r;
    int          exp_r;
    sig_r = {1'b0, sig_in} + 25'(guard & (sticky | sig_in[0]));
    exp_r = exp_in;
    if (sig_r[24]) begin
      sig_r = sig_r >> 1;
      exp_r = exp_r + 1;
    end
    if (exp_r >= 255) return {sign, 8'hFF, 23'h0};
    if (exp_r <= 0)   return {sign, 31'h0};
    return {sign, exp_r[7:0], sig_r[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a_raw, input logic [31:0] b_raw);
    logic [31:0] a, b;
    logic        sign, a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
    logic [47:0] prod;
    int          exp_p;
    a      = ftz(a_raw);
    b      = ftz(b_raw);
    sign   = a[31] ^ b[31];
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    a_zero = (a[30:0] == 31'h0);
    b_zero = (b[30:0] == 31'h0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
    if (a_inf || b_inf)   return {sign, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {sign, 31'h0};
    prod  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    exp_p = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) return pack_round(sign, exp_p + 1, prod[47:24], prod[23], |prod[22:0]);
    return pack_round(sign, exp_p, prod[46:23], prod[22], |prod[21:0]);
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a_raw, input logic [31:0] b_raw);
    logic [31:0] a, b, big, sml;
    logic        a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
    logic [7:0]  d;
    logic [49:0] big_x, sml_full, sml_x;
    logic [50:0] sum;
    int          lz, exp_s;
    a      = ftz(a_raw);
    b      = ftz(b_raw);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    a_zero = (a[30:0] == 31'h0);
    b_zero = (b[30:0] == 31'h0);
    if (a_nan || b_nan) return QNAN;
    if (a_inf && b_inf) return (a[31] == b[31]) ? a : QNAN;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'h0};
    if (a_zero) return b;
    if (b_zero) return a;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    // 26 extra low bits plus a sticky LSB keep guard/sticky exact through any cancellation.
    d        = big[30:23] - sml[30:23];
    big_x    = {1'b1, big[22:0], 26'h0};
    sml_full = {1'b1, sml[22:0], 26'h0};
    sml_x    = (sml_full >> d) | 50'(|(sml_full & ~({50{1'b1}} << d)));
    if (big[31] == sml[31]) sum = {1'b0, big_x} + {1'b0, sml_x};
    else                    sum = {1'b0, big_x} - {1'b0, sml_x};
    if (sum == 51'h0) return 32'h0;
    lz = 51;
    for (int i = 0; i <= 50; i++) begin
      if (sum[i]) lz = 50 - i;
    end
    sum   = sum << lz;
    exp_s = int'(big[30:23]) + 1 - lz;
    return pack_round(big[31], exp_s, sum[50:27], sum[26], |sum[25:0]);
  endfunction

  // NOTE: coefficients are configuration, not state: reset leaves them alone so a bench
  // or loader can rewrite them at any time.
  coeff_vec_t  coeffs = default_coeffs();
  hist_vec_t   hist_q;
  coeff_vec_t  taps;
  logic [31:0] acc;

  // taps is the post-shift line: taps[0] is the incoming sample.
  assign taps = {data_in, hist_q};

  always_comb begin
    // NOTE: blocking '=' is intended here; acc is a chain evaluated in tap order, and its
    // initial assignment also keeps this block free of latches.
    acc = 32'h0;
    for (int k = 0; k < TAP_CNT; k++) begin
      acc = fadd(acc, fmul(coeffs[k], taps[k]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q    <= '0;
      valid_out <= 1'b0;
      data_out  <= 32'h0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        hist_q   <= taps[0:TAP_CNT-2];
        data_out <= acc;
      end
    end
  end

endmodule

// File: tb/tb_highpass_fir.sv
// Directed bench for highpass_fir: impulse responses, gaps, async reset, special values.
module tb_highpass_fir;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic        valid_out;
  logic [31:0] data_out;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] HALF [0:15] = '{
    32'hA1381601, 32'hBA9DBDB2, 32'hBB36C8A9, 32'hBB8AC191,
    32'hBB816A82, 32'h22325551, 32'h3C07824B, 32'h3C987E0D,
    32'h3CD058CF, 32'h3CAE415B, 32'hA2DD7A7A, 32'hBD226DB2,
    32'hBDBC821D, 32'hBE14D580, 32'hBE3DA98F, 32'h3F4CCCCD
  };

  logic [31:0] c [0:30];

  highpass_fir #(.TAP_CNT(31)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between clock edges and checks that the outputs clear without a clock.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_rst_valid"}, {31'h0, valid_out}, 32'h0);
    check({tag, "_rst_data"}, data_out, 32'h0);
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 32'h0;
    rst      = 1'b1;
  endtask

  logic [31:0] dc_ref;
  shortreal    dc_val;

  initial begin
    for (int i = 0; i < 16; i++) begin
      c[i]    = HALF[i];
      c[30-i] = HALF[i];
    end
    rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;
    #2;
    check("por_valid", {31'h0, valid_out}, 32'h0);
    check("por_data", data_out, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Unit impulse: the response is the coefficient list itself.
    for (int k = 0; k < 31; k++) begin
      step(1'b1, (k == 0) ? 32'h3F800000 : 32'h0);
      check($sformatf("imp_data%0d", k), data_out, c[k]);
      check($sformatf("imp_valid%0d", k), {31'h0, valid_out}, 32'h1);
    end
    step(1'b0, 32'h0);
    check("idle_valid", {31'h0, valid_out}, 32'h0);
    check("idle_hold", data_out, c[30]);

    // Impulse of 2.0: every coefficient with its exponent raised by one.
    do_reset("scaled");
    for (int k = 0; k < 31; k++) begin
      step(1'b1, (k == 0) ? 32'h40000000 : 32'h0);
      check($sformatf("x2_data%0d", k), data_out, c[k] + 32'h0080_0000);
    end

    // Impulse of -1.0: sign-flipped coefficients.
    do_reset("neg");
    for (int k = 0; k < 16; k++) begin
      step(1'b1, (k == 0) ? 32'hBF800000 : 32'h0);
      check($sformatf("neg_data%0d", k), data_out, c[k] ^ 32'h8000_0000);
    end

    // Two unit samples: c0+c1 rounds to c1 (sticky only), c1+c2 is a real add.
    do_reset("pair");
    step(1'b1, 32'h3F800000);
    check("pair0", data_out, c[0]);
    step(1'b1, 32'h3F800000);
    check("pair1", data_out, 32'hBA9DBDB2);
    step(1'b1, 32'h0);
    check("pair2", data_out, 32'hBB82D3C1);

    // 1.5 times the 0.8 centre tap rounds up to 3F99999A.
    do_reset("rnd");
    for (int k = 0; k < 16; k++) step(1'b1, (k == 0) ? 32'h3FC00000 : 32'h0);
    check("rnd_centre", data_out, 32'h3F99999A);

    // Subnormal input flushes to zero; signed zero products sum to +0.
    do_reset("sub");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, (k == 0) ? 32'h00400000 : 32'h0);
      check($sformatf("sub_data%0d", k), data_out, 32'h0);
    end

    // Gaps of three idle cycles (with junk on data_in) must not disturb the response.
    do_reset("gap");
    for (int k = 0; k < 31; k++) begin
      step(1'b1, (k == 0) ? 32'h3F800000 : 32'h0);
      check($sformatf("gap_data%0d", k), data_out, c[k]);
      if (k == 5 || k == 20) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 32'h3F800000);
          check($sformatf("gap_valid%0d_%0d", k, g), {31'h0, valid_out}, 32'h0);
          check($sformatf("gap_hold%0d_%0d", k, g), data_out, c[k]);
        end
      end
    end

    // Mid-stream reset: the earlier impulse must be gone from the history afterwards.
    do_reset("mid_pre");
    step(1'b1, 32'h3F800000);
    step(1'b1, 32'h0);
    check("mid_stream", data_out, c[1]);
    do_reset("mid");
    step(1'b1, 32'h3F800000);
    check("mid_after0", data_out, c[0]);
    step(1'b1, 32'h0);
    check("mid_after1", data_out, c[1]);

    // DC step: once the line is full the output is small (about -1.7e-3 for this set) and constant.
    do_reset("dc");
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 32'h3F800000);
      if (k == 0) check("dc_first", data_out, c[0]);
      if (k == 30) dc_ref = data_out;
      if (k >= 30) begin
        dc_val = $bitstoshortreal(data_out);
        check($sformatf("dc_small%0d", k), {31'h0, (dc_val < 1.0e-2) && (dc_val > -1.0e-2)}, 32'h1);
      end
      if (k > 30) check($sformatf("dc_const%0d", k), data_out, dc_ref);
    end

    // Single +Inf: Inf times a finite nonzero tap is a signed Inf; no NaN arises.
    do_reset("inf");
    for (int k = 0; k < 31; k++) begin
      step(1'b1, (k == 0) ? 32'h7F800000 : 32'h0);
      if (k == 0)  check("inf0", data_out, 32'hFF800000);
      if (k == 5)  check("inf5", data_out, 32'h7F800000);
      if (k == 15) check("inf15", data_out, 32'h7F800000);
    end
    step(1'b1, 32'h0);
    check("inf_gone", data_out, 32'h0);

    // Two +Inf samples: taps 4 (negative) and 5 (positive) give Inf-Inf.
    do_reset("inf2");
    for (int k = 0; k < 7; k++) begin
      step(1'b1, (k < 2) ? 32'h7F800000 : 32'h0);
      if (k == 1) check("inf2_same", data_out, 32'hFF800000);
      if (k == 5) check("inf2_cancel", data_out, 32'h7FC00000);
      if (k == 6) check("inf2_pos", data_out, 32'h7F800000);
    end

    // NaN input is canonicalised.
    do_reset("nan");
    step(1'b1, 32'hFF812345);
    check("nan_in", data_out, 32'h7FC00000);

    // Rewritten coefficients: Inf*0 gives NaN, and 2*max overflows to +Inf.
    do_reset("coef");
    dut.coeffs[0] = 32'h0;
    step(1'b1, 32'h7F800000);
    check("inf_x_zero", data_out, 32'h7FC00000);
    do_reset("ovf");
    dut.coeffs[0] = 32'h40000000;
    step(1'b1, 32'h7F7FFFFF);
    check("overflow", data_out, 32'h7F800000);
    dut.coeffs[0] = c[0];
    do_reset("restore");
    step(1'b1, 32'h3F800000);
    check("restored", data_out, c[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
